// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the synchronous FIFO.
// Imported by the storage array and the FIFO top.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH register array.
// Synchronous write port, registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // storage write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // registered read data, cleared by reset, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data.
// Overflowing writes and underflowing reads are dropped.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_e,
  input  logic                  read_e,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT =
    (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // acceptance judged on pre-edge flags; reset masks both
  assign wr_acc = write_e && !full && !reset;
  assign rd_acc = read_e && !empty && !reset;

  // occupancy next-state
  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      (wr_acc && !rd_acc): count_nxt = count + 1'b1;
      (rd_acc && !wr_acc): count_nxt = count - 1'b1;
      default:             count_nxt = count;
    endcase
  end

  // pointer and occupancy registers; power-of-two depth wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random checks of sync_fifo
// against a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_e = 1'b0;
  logic       read_e = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout = '0;

  always #5 clk = ~clk;

  sync_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .write_e  (write_e),
    .read_e   (read_e),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // one clock edge: drive, update model, compare
  task automatic step(input logic rst, input logic we,
                      input logic re, input logic [7:0] din,
                      input string tag);
    bit wacc;
    bit racc;
    reset   = rst;
    write_e = we;
    read_e  = re;
    data_in = din;
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_dout = '0;
    end else begin
      wacc = we && (q.size() < 8);
      racc = re && (q.size() > 0);
      if (racc) exp_dout = q.pop_front();
      if (wacc) q.push_back(din);
    end
    #1;
    chk({tag, ".dout"}, 32'(data_out), 32'(exp_dout));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == 8));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
  endtask

  logic [7:0] fill_d [9] = '{8'h03, 8'h09, 8'h07, 8'h03,
                             8'h09, 8'h07, 8'h03, 8'h09,
                             8'h17};

  initial begin
    // reset with a write pending
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 8'hEE, "rst");
    chk("rst.empty_c", 32'(empty), 32'd1);
    chk("rst.full_c", 32'(full), 32'd0);
    chk("rst.dout_c", 32'(data_out), 32'd0);

    // fill with one overflowing write
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b0, fill_d[i], "fill");
      chk("fill.nonempty", 32'(empty), 32'd0);
      if (i == 6) chk("fill.notfull7", 32'(full), 32'd0);
      if (i >= 7) chk("fill.full", 32'(full), 32'd1);
    end

    // drain with two underflowing reads
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00, "drain");
      chk("drain.val", 32'(data_out),
          32'(fill_d[(i < 8) ? i : 7]));
      if (i == 0) chk("drain.notfull", 32'(full), 32'd0);
      if (i == 6) chk("drain.notempty", 32'(empty), 32'd0);
      if (i >= 7) chk("drain.empty", 32'(empty), 32'd1);
    end

    // three stored, then simultaneous traffic across wrap
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i), "pre3");
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b1, 8'($urandom), "rw3");

    // top up to full, then read+write while full
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 8'($urandom), "top");
    chk("top.full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 1'b1, 8'hCC, "rwfull");
    chk("rwfull.notfull", 32'(full), 32'd0);
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, 1'b1, 8'h00, "drain7");
    chk("drain7.empty", 32'(empty), 32'd1);

    // read+write while empty: write only
    step(1'b0, 1'b1, 1'b1, 8'h5A, "rwempty");
    chk("rwempty.nonempty", 32'(empty), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00, "rwempty_rd");
    chk("rwempty.val", 32'(data_out), 32'h5A);

    // reset with five stored
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 8'(8'h70 + i), "pre5");
    step(1'b1, 1'b1, 1'b1, 8'h11, "midrst");
    chk("midrst.empty", 32'(empty), 32'd1);
    chk("midrst.dout", 32'(data_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'hA5, "postrst_wr");
    step(1'b0, 1'b0, 1'b1, 8'h00, "postrst_rd");
    chk("postrst.val", 32'(data_out), 32'hA5);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) == 0),
           1'($urandom), 1'($urandom),
           8'($urandom), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
